tx_zc_seq_gen: RTL and testbench

- Streaming generator for NR low-PAPR Zadoff-Chu-type base sequences of length 6, 12, 18 or 24, with cyclic shift applied.
- Reads the base phase of each sample through the existing 3-bit phase lookup table (tx_zc_table) and adds the cyclic-shift phase ramp alpha·n.
- Emits combined phase indices in units of pi/12 (24 phases per circle) over a valid/ready stream to the modulator, with repetition over several symbols.

---
 rtl/tx_zc_seq_gen.sv | 199 +++++++++++++++++++
 tb/tb_tx_zc_seq_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_zc_seq_gen.sv
// Streaming low-PAPR ZC-type base sequence generator: table lookup plus cyclic-shift ramp,
// emitted in pi/12 phase units through a small first-word fall-through FIFO.
module tx_zc_seq_gen #(
   parameter int unsigned PHASE_W    = 5,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned REP_W      = 4
) (
   input  logic               sys_clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         len_sel,
   input  logic [4:0]         u,
   input  logic [3:0]         n_cs,
   input  logic [REP_W-1:0]   rep_num,
   output logic               busy,
   output logic               tbl_en,
   output logic [4:0]         tbl_u,
   output logic [4:0]         tbl_n,
   output logic [4:0]         tbl_m_zc,
   input  logic [2:0]         tbl_fine,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PHASE_W-1:0] out_phase,
   output logic               out_last_sym,
   output logic               out_last,
   output logic               done,
   output logic               err
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned ENT_W = PHASE_W + 2;

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e             state_q, state_d;
   logic [4:0]         u_q, u_d;
   logic [4:0]         ncs2_q, ncs2_d;
   logic [4:0]         len_m1_q, len_m1_d;
   logic [4:0]         m_zc_q, m_zc_d;
   logic [REP_W-1:0]   rep_last_q, rep_last_d;
   logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
   logic [4:0]         n_q, n_d;
   logic [4:0]         acc_q, acc_d;
   logic               err_q, err_d;
   logic               pend_q, pend_d;
   logic [4:0]         pend_acc_q, pend_acc_d;
   logic               pend_sym_q, pend_sym_d;
   logic               pend_last_q, pend_last_d;
   logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
   logic [ENT_W-1:0]   mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               pop, push, credit_ok, issue, wrap, last_rep, drained;
   logic [5:0]         acc_sum, merge_sum;
   logic [PHASE_W-1:0] merge_phase;
   logic [ENT_W-1:0]   head;

   always_comb begin
      pop       = (cnt_q != '0) && out_ready;
      push      = pend_q;
      // A pop this cycle frees a slot in time for a lookup issued now, keeping one sample/cycle.
      credit_ok = (32'(cnt_q) + 32'(pend_q)) < (FIFO_DEPTH + 32'(pop));
      issue     = (state_q == StRun) && credit_ok;
      wrap      = (n_q == len_m1_q);
      last_rep  = (rep_cnt_q == rep_last_q);
      drained   = (state_q == StDrain) && (cnt_q == '0) && !pend_q;
      acc_sum   = {1'b0, acc_q} + {1'b0, ncs2_q};
      merge_sum = ({3'b000, tbl_fine} * 6'd3) + {1'b0, pend_acc_q};
      merge_phase = PHASE_W'((merge_sum >= 6'd24) ? (merge_sum - 6'd24) : merge_sum);
      head      = mem_q[rd_ptr_q];
   end

   always_comb begin
      state_d     = state_q;
      u_d         = u_q;
      ncs2_d      = ncs2_q;
      len_m1_d    = len_m1_q;
      m_zc_d      = m_zc_q;
      rep_last_d  = rep_last_q;
      rep_cnt_d   = rep_cnt_q;
      n_d         = n_q;
      acc_d       = acc_q;
      err_d       = 1'b0;
      pend_d      = 1'b0;
      pend_acc_d  = pend_acc_q;
      pend_sym_d  = pend_sym_q;
      pend_last_d = pend_last_q;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q + CNT_W'(push) - CNT_W'(pop);

      if (start) begin
         if ((state_q != StIdle) || (u > 5'd29) || (n_cs > 4'd11)) begin
            err_d = 1'b1;
         end else begin
            state_d    = StRun;
            u_d        = u;
            ncs2_d     = {n_cs, 1'b0};
            rep_last_d = (rep_num == '0) ? '0 : rep_num - 1'b1;
            rep_cnt_d  = '0;
            n_d        = '0;
            acc_d      = '0;
            case (len_sel)
               2'd0:    begin len_m1_d = 5'd5;  m_zc_d = 5'd6;  end
               2'd1:    begin len_m1_d = 5'd11; m_zc_d = 5'd12; end
               2'd2:    begin len_m1_d = 5'd17; m_zc_d = 5'd16; end
               default: begin len_m1_d = 5'd23; m_zc_d = 5'd24; end
            endcase
         end
      end

      if (issue) begin
         pend_d      = 1'b1;
         pend_acc_d  = acc_q;
         pend_sym_d  = wrap;
         pend_last_d = wrap && last_rep;
         if (wrap) begin
            n_d       = '0;
            acc_d     = '0;
            rep_cnt_d = rep_cnt_q + 1'b1;
            if (last_rep) state_d = StDrain;
         end else begin
            n_d   = n_q + 5'd1;
            acc_d = (acc_sum >= 6'd24) ? 5'(acc_sum - 6'd24) : acc_sum[4:0];
         end
      end

      if (drained) state_d = StIdle;

      if (push) begin
         mem_d[wr_ptr_q] = {pend_last_q, pend_sym_q, merge_phase};
         wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         u_q         <= '0;
         ncs2_q      <= '0;
         len_m1_q    <= '0;
         m_zc_q      <= '0;
         rep_last_q  <= '0;
         rep_cnt_q   <= '0;
         n_q         <= '0;
         acc_q       <= '0;
         err_q       <= 1'b0;
         pend_q      <= 1'b0;
         pend_acc_q  <= '0;
         pend_sym_q  <= 1'b0;
         pend_last_q <= 1'b0;
         mem_q       <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         u_q         <= u_d;
         ncs2_q      <= ncs2_d;
         len_m1_q    <= len_m1_d;
         m_zc_q      <= m_zc_d;
         rep_last_q  <= rep_last_d;
         rep_cnt_q   <= rep_cnt_d;
         n_q         <= n_d;
         acc_q       <= acc_d;
         err_q       <= err_d;
         pend_q      <= pend_d;
         pend_acc_q  <= pend_acc_d;
         pend_sym_q  <= pend_sym_d;
         pend_last_q <= pend_last_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
      end
   end

   assert property (@(posedge sys_clk) disable iff (rst)
      !(push && !pop && (32'(cnt_q) == FIFO_DEPTH)));

   assign busy         = (state_q != StIdle);
   assign tbl_en       = issue;
   assign tbl_u        = u_q;
   assign tbl_n        = n_q;
   assign tbl_m_zc     = m_zc_q;
   assign out_valid    = (cnt_q != '0);
   assign out_phase    = out_valid ? head[PHASE_W-1:0] : '0;
   assign out_last_sym = out_valid && head[PHASE_W];
   assign out_last     = out_valid && head[PHASE_W+1];
   assign done         = drained;
   assign err          = err_q;

endmodule

// File: tb/tb_tx_zc_seq_gen.sv
// Bench for tx_zc_seq_gen: a stand-in phase table, a sequence model computed from
// phase = 3*fine + 2*n_cs*n (mod 24), and a per-cycle stream/done checker.
module tb_tx_zc_seq_gen;

   logic       sys_clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [1:0] len_sel = '0;
   logic [4:0] u = '0;
   logic [3:0] n_cs = '0;
   logic [3:0] rep_num = '0;
   logic       busy, tbl_en;
   logic [4:0] tbl_u, tbl_n, tbl_m_zc;
   logic [2:0] tbl_fine;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [4:0] out_phase;
   logic       out_last_sym, out_last, done, err;

   tx_zc_seq_gen #(.PHASE_W(5), .FIFO_DEPTH(2), .REP_W(4)) dut (
      .sys_clk(sys_clk), .rst(rst), .start(start), .len_sel(len_sel), .u(u), .n_cs(n_cs),
      .rep_num(rep_num), .busy(busy), .tbl_en(tbl_en), .tbl_u(tbl_u), .tbl_n(tbl_n),
      .tbl_m_zc(tbl_m_zc), .tbl_fine(tbl_fine), .out_valid(out_valid), .out_ready(out_ready),
      .out_phase(out_phase), .out_last_sym(out_last_sym), .out_last(out_last), .done(done),
      .err(err)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {int phase; bit sym; bit last;} exp_t;
   exp_t exp_q[$];
   exp_t cur;
   int   got_q[$];
   int   n_checks = 0;
   int   n_errs = 0;
   int   n_acc = 0;
   bit   exp_done_now = 1'b0;
   bit   rdy_mode = 1'b0;
   bit   rdy_val = 1'b1;

   // Stand-in table: u=0, M=6 row matches the real table; other rows are arbitrary but fixed.
   function automatic int tbl_f(input int uu, input int nn, input int mm);
      int base6[6];
      base6 = '{5, 7, 3, 3, 7, 5};
      if (uu == 0 && mm == 6) return base6[nn % 6];
      return (uu * 5 + nn * nn * 3 + mm) % 8;
   endfunction

   always @(posedge sys_clk or posedge rst) begin
      if (rst) tbl_fine <= '0;
      else if (tbl_en) tbl_fine <= 3'(tbl_f(int'(tbl_u), int'(tbl_n), int'(tbl_m_zc)));
   end

   always @(posedge sys_clk) begin
      #2 out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_val;
   end

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge sys_clk) begin
      if (rst) begin
         exp_done_now = 1'b0;
      end else begin
         check("done", int'(done), int'(exp_done_now));
         exp_done_now = 1'b0;
         if (out_valid && out_ready) begin
            n_acc++;
            got_q.push_back(int'(out_phase));
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errs++;
               $display("FAIL extra_sample: got phase %0d expected none", out_phase);
            end else begin
               cur = exp_q.pop_front();
               check("phase", int'(out_phase), cur.phase);
               check("last_sym", int'(out_last_sym), int'(cur.sym));
               check("last", int'(out_last), int'(cur.last));
               if (cur.last) exp_done_now = 1'b1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic model_push(input int ls, input int uu, input int ncs, input int rep);
      int len, mzc, reps;
      exp_t e;
      len  = (ls + 1) * 6;
      mzc  = (ls == 2) ? 16 : len;
      reps = (rep == 0) ? 1 : rep;
      for (int r = 0; r < reps; r++) begin
         for (int n = 0; n < len; n++) begin
            e.phase = (3 * tbl_f(uu, n, mzc) + 2 * ncs * n) % 24;
            e.sym   = (n == len - 1);
            e.last  = (n == len - 1) && (r == reps - 1);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic pulse_start(input int ls, input int uu, input int ncs, input int rep);
      len_sel = 2'(ls);
      u       = 5'(uu);
      n_cs    = 4'(ncs);
      rep_num = 4'(rep);
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   task automatic launch(input int ls, input int uu, input int ncs, input int rep);
      got_q.delete();
      n_acc = 0;
      model_push(ls, uu, ncs, rep);
      pulse_start(ls, uu, ncs, rep);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int cnt;
      cnt = 0;
      while (busy && cnt < budget) begin
         tick();
         cnt++;
      end
      if (busy) begin
         n_checks++;
         n_errs++;
         $display("FAIL %s_timeout: still busy after %0d cycles", name, budget);
      end
      tick();
      check({name, "_leftover"}, exp_q.size(), 0);
   endtask

   initial begin
      int lit1[6];
      int lit2[6];
      lit1 = '{15, 21, 9, 9, 21, 15};
      lit2 = '{15, 23, 13, 15, 5, 1};

      tick();
      tick();
      check("rst_busy", int'(busy), 0);
      check("rst_valid", int'(out_valid), 0);
      check("rst_tbl_n", int'(tbl_n), 0);
      check("rst_tbl_m_zc", int'(tbl_m_zc), 0);
      rst = 1'b0;
      tick();

      // Basic length-6 sequence with latency check
      launch(0, 0, 0, 1);
      check("t1_busy", int'(busy), 1);
      check("t1_valid_c0", int'(out_valid), 0);
      tick();
      check("t1_valid_c1", int'(out_valid), 0);
      tick();
      check("t1_valid_c2", int'(out_valid), 1);
      wait_idle("t1", 100);
      check("t1_count", got_q.size(), 6);
      for (int i = 0; i < 6 && i < got_q.size(); i++) check("t1_literal", got_q[i], lit1[i]);

      // Cyclic shift 1: acc wraps past 24
      launch(0, 0, 1, 1);
      wait_idle("t2", 100);
      check("t2_count", got_q.size(), 6);
      for (int i = 0; i < 6 && i < got_q.size(); i++) check("t2_literal", got_q[i], lit2[i]);

      // Length 24, three repetitions, random backpressure
      rdy_mode = 1'b1;
      launch(3, 17, 11, 3);
      wait_idle("t3", 2000);
      check("t3_count", n_acc, 72);
      rdy_mode = 1'b0;
      rdy_val  = 1'b1;
      tick();

      // Mid-run stall of 10 cycles
      launch(3, 7, 5, 2);
      repeat (10) tick();
      rdy_val = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i >= 3) begin
            check("t4_tbl_en_stalled", int'(tbl_en), 0);
            check("t4_valid_held", int'(out_valid), 1);
         end
      end
      rdy_val = 1'b1;
      wait_idle("t4", 500);
      check("t4_count", n_acc, 48);

      // Illegal starts in IDLE
      pulse_start(0, 30, 0, 1);
      check("t5_err_u", int'(err), 1);
      check("t5_busy_u", int'(busy), 0);
      tick();
      check("t5_err_clear", int'(err), 0);
      pulse_start(0, 3, 12, 1);
      check("t5_err_ncs", int'(err), 1);
      check("t5_busy_ncs", int'(busy), 0);
      tick();

      // Start while running is rejected and the run completes unchanged
      launch(1, 3, 4, 2);
      repeat (3) tick();
      pulse_start(3, 9, 2, 5);
      check("t6_err_run", int'(err), 1);
      check("t6_busy_run", int'(busy), 1);
      wait_idle("t6", 500);
      check("t6_count", n_acc, 24);

      // Reset mid-run with a full FIFO, then a clean run with rep_num=0
      rdy_val = 1'b0;
      launch(3, 12, 6, 2);
      repeat (6) tick();
      check("t7_full_valid", int'(out_valid), 1);
      rst = 1'b1;
      #1;
      exp_q.delete();
      check("t7_rst_busy", int'(busy), 0);
      check("t7_rst_valid", int'(out_valid), 0);
      check("t7_rst_tbl_en", int'(tbl_en), 0);
      check("t7_rst_phase", int'(out_phase), 0);
      check("t7_rst_tbl_n", int'(tbl_n), 0);
      check("t7_rst_tbl_u", int'(tbl_u), 0);
      check("t7_rst_done", int'(done), 0);
      tick();
      rst = 1'b0;
      rdy_val = 1'b1;
      tick();
      launch(2, 9, 7, 0);
      wait_idle("t8", 300);
      check("t8_count", n_acc, 18);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
